// File: rtl/tbuf_ctl.sv
// tbuf_ctl: ping-pong cube transpose buffer.
// Two banks each hold one N x N x N frame of DW-bit elements.
// The writer fills one bank while the reader drains the other. The reader
// can present the cube in natural order, with the a/c axes swapped, or with
// the a/b axes swapped.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   wr_valid   write beat offered
//   wr_ready   write beat accepted when wr_valid && wr_ready
//   wr_data    P lanes of DW bits; lane i in [i*DW +: DW]
//   rd_mode    read permutation, captured on the first fetch of a bank
//   rd_valid   read beat present (registered)
//   rd_ready   consumer accepts the beat when rd_valid && rd_ready
//   rd_data    P lanes of DW bits (registered)
//   rd_last    marks the final beat of a frame (registered)
//   bank_full  per-bank "frame complete, not yet drained" flags
module tbuf_ctl #(
  parameter int DW = 64,
  parameter int N  = 96,
  parameter int P  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [P*DW-1:0] wr_data,
  input  logic [1:0]      rd_mode,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [P*DW-1:0] rd_data,
  output logic            rd_last,
  output logic [1:0]      bank_full
);

  localparam int FR = N * N * N;
  localparam int NG = N / P;
  localparam int AW = $clog2(2 * FR);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(N - 1);
  localparam logic [GW-1:0] G_MAX = GW'(NG - 1);

  // Flat storage: bank 1 sits directly above bank 0.
  logic [DW-1:0] r_mem [0:2*FR-1];

  logic          r_wbank, r_rbank;
  logic [CW-1:0] r_wc, r_wb, r_rc, r_rb;
  logic [GW-1:0] r_wg, r_rg;
  logic [1:0]    r_mode_q;
  logic          r_started;   // current read bank has had its first fetch
  logic          r_drained;   // every beat of the current read bank fetched
  logic [1:0]    r_bank_full;
  logic          r_rd_valid, r_rd_last;
  logic [P*DW-1:0] r_rd_data;

  logic       w_wr_acc, w_wr_end, w_fetch, w_fetch_end, w_rd_hs_last;
  logic [1:0] w_mode;
  logic [1:0] w_bank_full_nxt;

  function automatic logic [AW-1:0] f_addr(input logic bank, input int a,
                                           input int b, input int c);
    int idx;
    idx = (bank ? FR : 0) + a * N * N + b * N + c;
    return AW'(idx);
  endfunction

  // Address of lane `lane` for read counters (g, b, c) under permutation `mode`.
  function automatic logic [AW-1:0] f_rd_addr(input logic bank, input logic [1:0] mode,
                                              input int g, input int b, input int c,
                                              input int lane);
    case (mode)
      2'd1:    return f_addr(bank, c, b, P * g + lane);
      2'd2:    return f_addr(bank, b, P * g + lane, c);
      default: return f_addr(bank, P * g + lane, b, c);
    endcase
  endfunction

  assign wr_ready  = !r_bank_full[r_wbank];
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = r_rd_data;
  assign bank_full = r_bank_full;

  assign w_wr_acc     = wr_valid && !r_bank_full[r_wbank];
  assign w_wr_end     = w_wr_acc && (r_wc == C_MAX) && (r_wb == C_MAX) && (r_wg == G_MAX);
  assign w_fetch      = r_bank_full[r_rbank] && !r_drained && (!r_rd_valid || rd_ready);
  assign w_fetch_end  = w_fetch && (r_rc == C_MAX) && (r_rb == C_MAX) && (r_rg == G_MAX);
  assign w_rd_hs_last = r_rd_valid && rd_ready && r_rd_last;
  // Until the first fetch the live rd_mode is used, so that fetch already sees it.
  assign w_mode       = r_started ? r_mode_q : rd_mode;

  // Set and clear address different banks, so both always land together.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_end)     w_bank_full_nxt[r_wbank] = 1'b1;
    if (w_rd_hs_last) w_bank_full_nxt[r_rbank] = 1'b0;
  end

  // Write stage: scatter P lanes into the write bank.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      for (int i = 0; i < P; i++) begin
        r_mem[f_addr(r_wbank, P * int'(r_wg) + i, int'(r_wb), int'(r_wc))] <= wr_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_wc        <= '0;
      r_wb        <= '0;
      r_wg        <= '0;
      r_rc        <= '0;
      r_rb        <= '0;
      r_rg        <= '0;
      r_mode_q    <= 2'd0;
      r_started   <= 1'b0;
      r_drained   <= 1'b0;
      r_bank_full <= 2'b00;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_bank_full <= w_bank_full_nxt;

      if (w_wr_acc) begin
        if (r_wc == C_MAX) begin
          r_wc <= '0;
          if (r_wb == C_MAX) begin
            r_wb <= '0;
            r_wg <= (r_wg == G_MAX) ? '0 : r_wg + GW'(1);
          end else begin
            r_wb <= r_wb + CW'(1);
          end
        end else begin
          r_wc <= r_wc + CW'(1);
        end
        if (w_wr_end) r_wbank <= ~r_wbank;
      end

      // Read stage: gather P lanes into the output register.
      if (w_fetch) begin
        for (int i = 0; i < P; i++) begin
          r_rd_data[i*DW +: DW] <= r_mem[f_rd_addr(r_rbank, w_mode, int'(r_rg),
                                                   int'(r_rb), int'(r_rc), i)];
        end
        r_rd_valid <= 1'b1;
        r_rd_last  <= w_fetch_end;
        r_mode_q   <= w_mode;
        r_started  <= 1'b1;
        if (w_fetch_end) r_drained <= 1'b1;
        if (r_rc == C_MAX) begin
          r_rc <= '0;
          if (r_rb == C_MAX) begin
            r_rb <= '0;
            r_rg <= (r_rg == G_MAX) ? '0 : r_rg + GW'(1);
          end else begin
            r_rb <= r_rb + CW'(1);
          end
        end else begin
          r_rc <= r_rc + CW'(1);
        end
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
      end

      // The last beat never coincides with a fetch: r_drained blocks it.
      if (w_rd_hs_last) begin
        r_rbank   <= ~r_rbank;
        r_started <= 1'b0;
        r_drained <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tbuf_ctl.md
TBUF_CTL -- requirements
Module: tbuf_ctl

Interface
REQ-001 Parameter DW, 64, bits per element (complex word).
REQ-002 Parameter N, 96, cube side; SHALL be a multiple of P; frame = N^3 elements.
REQ-003 Parameter P, 32, lanes per beat; beats per frame B = N^3/P.
REQ-004 Port clock  in  1  rising-edge clock.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port wr_valid  in  1  write beat offered.
REQ-007 Port wr_ready  out  1  write beat accepted when wr_valid&&wr_ready.
REQ-008 Port wr_data  in  P*DW  lane i in bits [i*DW +: DW].
REQ-009 Port rd_mode  in  2  read permutation; sampled when a bank starts draining.
REQ-010 Port rd_valid  out  1  read beat present.
REQ-011 Port rd_ready  in  1  consumer accepts the beat when rd_valid&&rd_ready.
REQ-012 Port rd_data  out  P*DW  lane i in bits [i*DW +: DW].
REQ-013 Port rd_last  out  1  high with the final beat of a frame.
REQ-014 Port bank_full  out  2  per-bank "frame complete, not yet drained" flag.

Function
REQ-015 Storage: two banks (ping-pong) of N^3 x DW each; element (a,b,c) at address a*N*N + b*N + c.
REQ-016 Write counters wc (fastest), wb, wg: wc/wb in 0..N-1, wg in 0..N/P-1; each accepted beat writes lane i to (P*wg+i, wb, wc) of bank wbank.
REQ-017 wr_ready = !bank_full[wbank]; beats offered while wr_ready=0 are ignored, with no state change.
REQ-018 On acceptance of beat B-1: set bank_full[wbank], toggle wbank, clear write counters.
REQ-019 Read counters rc (fastest), rb, rg, same ranges; a bank drains only when bank_full[rbank]=1; rd_mode is latched into mode_q on the first fetch of that bank.
REQ-020 mode_q=0: lane i reads (P*rg+i, rb, rc).
REQ-021 mode_q=1: lane i reads (rc, rb, P*rg+i) (a<->c transpose).
REQ-022 mode_q=2: lane i reads (rb, P*rg+i, rc) (a<->b transpose); mode_q=3 behaves as 0.
REQ-023 rd_data/rd_valid/rd_last SHALL be registered. A fetch occurs when bank_full[rbank] is set, unread beats remain, and (rd_valid=0 or rd_ready=1). Latency from bank_full rising to the first rd_valid is 1 cycle.
REQ-024 While rd_valid=1 and rd_ready=0, rd_data and rd_last SHALL be held stable.
REQ-025 On the handshake of the rd_last beat: clear bank_full[rbank] and toggle rbank. The freed bank shows wr_ready=1 on the next cycle.
REQ-026 Back-to-back throughput: one beat per cycle on each side concurrently. Writing one bank while the other drains is legal.
REQ-027 Simultaneous set of one bank_full bit and clear of the other in the same cycle SHALL both take effect.
REQ-028 The write side never targets a bank with bank_full=1, so no read/write address collision is possible.

Reset
REQ-029 Reset clears wbank, rbank, all counters, mode_q, bank_full=2'b00, rd_valid=0, rd_last=0, and rd_data=0. After reset, wr_ready=1.
REQ-030 Memory contents are not cleared. Reset mid-frame discards the partial frame and any undrained frames; the next accepted beat is beat 0 of bank 0.

Verification (N=8, P=4, DW=16, B=128; write beat k lane i data = 4k+i)
REQ-031 Write one frame, rd_mode=0, rd_ready=1 -> first beat {0,1,2,3}, 128 beats in sequence, rd_last on beat 127, bank_full returns to 00.
REQ-032 Same frame with rd_mode=1 -> first beat {0,4,8,12}; rd_mode=2 -> first beat {0,32,64,96}.
REQ-033 Write 3 frames with rd_ready=0 -> wr_ready falls after 256 accepted beats, bank_full=11; release rd_ready -> wr_ready rises 1 cycle after frame-0 rd_last handshake.
REQ-034 Random rd_ready/wr_valid stalls -> rd_data stable while stalled; output matches the golden permutation model for all modes over 4 frames.
REQ-035 Assert reset at write beat 50 and during a drain -> bank_full=00, rd_valid=0 the next cycle; a following full frame reads back correctly.
